disk_track_loader: RTL



---
 rtl/apple2_disk_pkg.sv | 7 +
 rtl/disk_track_loader.sv | 108 ++++++++++
 2 files changed

// File: rtl/apple2_disk_pkg.sv
// apple2_disk_pkg: shared Disk II track loader states and geometry constants
package apple2_disk_pkg;
  localparam int TRACK_SECTORS = 13;
  localparam int TRACK_BYTES = 6656;
  localparam int LBA_W = 32;
  typedef enum logic [2:0] {IDLE, WB_REQ, WB_XFER, RD_REQ, RD_XFER, NEXT} load_state_t;
endpackage

// File: rtl/disk_track_loader.sv
// disk_track_loader: writes back a dirty track and streams the requested track between SD and track RAM
module disk_track_loader #(
  parameter int TRACK_SECTORS = 13,
  parameter int LBA_BASE = 0
) (
  input  logic                              CLK_14M,
  input  logic                              reset,
  input  logic [5:0]                        track,
  input  logic                              track_we,
  input  logic                              disk_ready,
  input  logic                              wp,
  output logic                              busy,
  output logic [apple2_disk_pkg::LBA_W-1:0] sd_lba,
  output logic                              sd_rd,
  output logic                              sd_wr,
  input  logic                              sd_ack,
  input  logic [8:0]                        sd_buff_addr,
  input  logic [7:0]                        sd_buff_dout,
  input  logic                              sd_buff_wr,
  output logic [7:0]                        sd_buff_din,
  output logic [12:0]                       ram_addr,
  output logic [7:0]                        ram_di,
  output logic                              ram_we,
  input  logic [7:0]                        ram_do
);
  import apple2_disk_pkg::*;
  localparam logic [3:0] LAST = 4'(TRACK_SECTORS - 1);
  load_state_t state;
  logic [5:0] cur_track, tgt_track;
  logic [3:0] sec;
  logic valid, dirty, wb;
  logic need_wb;
  function automatic logic [LBA_W-1:0] lba_of(input logic [5:0] t, input logic [3:0] s);
    return LBA_W'(LBA_BASE) + LBA_W'(t) * LBA_W'(TRACK_SECTORS) + LBA_W'(s);
  endfunction
  assign need_wb = valid & dirty & ~wp;
  assign ram_addr = (state == RD_XFER || state == WB_XFER) ? {sec, sd_buff_addr} : '0;
  assign ram_we = state == RD_XFER && sd_ack && sd_buff_wr;
  assign ram_di = state == RD_XFER ? sd_buff_dout : '0;
  assign sd_buff_din = state == WB_XFER ? ram_do : '0;
  always_ff @(posedge CLK_14M)
    if (reset) begin
      state <= IDLE;
      cur_track <= '0;
      tgt_track <= '0;
      sec <= '0;
      valid <= 1'b0;
      dirty <= 1'b0;
      wb <= 1'b0;
      busy <= 1'b0;
      sd_rd <= 1'b0;
      sd_wr <= 1'b0;
      sd_lba <= '0;
    end else
      case (state)
        IDLE:
          if (!disk_ready) begin
            valid <= 1'b0;
            dirty <= 1'b0;
          end else begin
            if (track_we && valid) dirty <= 1'b1;
            if (!valid || track != cur_track) begin
              tgt_track <= track;
              sec <= '0;
              busy <= 1'b1;
              wb <= need_wb;
              state <= need_wb ? WB_REQ : RD_REQ;
              sd_lba <= lba_of(need_wb ? cur_track : track, 4'd0);
            end
          end
        WB_REQ, RD_REQ:
          if ((sd_rd || sd_wr) && sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= wb ? WB_XFER : RD_XFER;
          end else begin
            sd_wr <= wb;
            sd_rd <= ~wb;
          end
        WB_XFER, RD_XFER:
          if (!sd_ack) state <= NEXT;
        NEXT:
          // a dropped mount aborts between sectors, never mid-handshake
          if (!disk_ready) begin
            valid <= 1'b0;
            dirty <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
          end else if (sec < LAST) begin
            sec <= sec + 4'd1;
            state <= wb ? WB_REQ : RD_REQ;
            sd_lba <= lba_of(wb ? cur_track : tgt_track, sec + 4'd1);
          end else if (wb) begin
            wb <= 1'b0;
            sec <= '0;
            dirty <= 1'b0;
            state <= RD_REQ;
            sd_lba <= lba_of(tgt_track, 4'd0);
          end else begin
            cur_track <= tgt_track;
            valid <= 1'b1;
            dirty <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule
